// File: rtl/writeback_stage.sv
// RV32I writeback stage: load extraction and extension, write suppression, misaligned-load
// flagging, a short history of committed writes for forwarding, and a retired counter.
module writeback_stage #(
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned BP_DEPTH = 2,
   parameter int unsigned CNT_W    = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [3:0]                 insn_type,
   input  logic [2:0]                 funct3,
   input  logic [1:0]                 addr_lo,
   input  logic [REG_AW-1:0]          rd,
   input  logic [31:0]                ex_val,
   input  logic                       mem_r_valid,
   input  logic [31:0]                mem_r_data,
   output logic                       regfile_w_en,
   output logic [REG_AW-1:0]          regfile_w_reg,
   output logic [31:0]                regfile_w_data,
   output logic [BP_DEPTH-1:0]        wb_bp_valid,
   output logic [BP_DEPTH*REG_AW-1:0] wb_bp_reg,
   output logic [BP_DEPTH*32-1:0]     wb_bp_val,
   output logic                       misalign_err,
   output logic [CNT_W-1:0]           retired
);

   // Instruction type codes shared with the execute stage.
   localparam logic [3:0] R_TYPE = 4'd0;
   localparam logic [3:0] I_TYPE = 4'd1;
   localparam logic [3:0] L_TYPE = 4'd2;
   localparam logic [3:0] S_TYPE = 4'd3;
   localparam logic [3:0] B_TYPE = 4'd4;
   localparam logic [3:0] J_TYPE = 4'd5;
   localparam logic [3:0] U_TYPE = 4'd6;

   typedef enum logic [0:0] {StIdle, StWaitMem} state_t;

   state_t              state;
   logic [2:0]          f3_q;
   logic [1:0]          addr_q;
   logic [REG_AW-1:0]   rd_q;

   logic                is_load;
   logic                done;
   logic                c_load;
   logic                c_writes;
   logic [2:0]          c_f3;
   logic [1:0]          c_addr;
   logic [REG_AW-1:0]   c_rd;
   logic [31:0]         lane_word;
   logic [7:0]          lane_b;
   logic [15:0]         lane_h;
   logic [31:0]         ld_data;
   logic                ld_err;
   logic                c_err;
   logic [31:0]         c_data;
   logic                c_we;

   // While waiting for memory, the completion uses the fields latched at acceptance.
   always_comb begin
      is_load = (insn_type == L_TYPE);
      c_f3    = funct3;
      c_addr  = addr_lo;
      c_rd    = rd;
      c_load  = is_load;
      done    = 1'b0;
      if (state == StIdle) begin
         done = in_valid && (!is_load || mem_r_valid);
      end else begin
         c_f3   = f3_q;
         c_addr = addr_q;
         c_rd   = rd_q;
         c_load = 1'b1;
         done   = mem_r_valid;
      end
      c_writes = c_load || !((insn_type == S_TYPE) || (insn_type == B_TYPE));
   end

   always_comb begin
      lane_word = mem_r_data >> {c_addr, 3'b000};
      lane_b    = lane_word[7:0];
      lane_h    = c_addr[1] ? mem_r_data[31:16] : mem_r_data[15:0];
      ld_data   = 32'h0;
      ld_err    = 1'b0;
      unique case (c_f3)
         3'b000: ld_data = {{24{lane_b[7]}}, lane_b};
         3'b100: ld_data = {24'h0, lane_b};
         3'b001: begin
            ld_data = {{16{lane_h[15]}}, lane_h};
            ld_err  = c_addr[0];
         end
         3'b101: begin
            ld_data = {16'h0, lane_h};
            ld_err  = c_addr[0];
         end
         3'b010: begin
            ld_data = mem_r_data;
            ld_err  = (c_addr != 2'b00);
         end
         default: ld_err = 1'b1;
      endcase
      c_err  = c_load && ld_err;
      c_data = c_load ? ld_data : ex_val;
      c_we   = c_writes && (c_rd != '0) && !c_err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= StIdle;
         in_ready       <= 1'b1;
         f3_q           <= 3'b000;
         addr_q         <= 2'b00;
         rd_q           <= '0;
         regfile_w_en   <= 1'b0;
         regfile_w_reg  <= '0;
         regfile_w_data <= 32'h0;
         wb_bp_valid    <= '0;
         wb_bp_reg      <= '0;
         wb_bp_val      <= '0;
         misalign_err   <= 1'b0;
         retired        <= '0;
      end else begin
         regfile_w_en <= 1'b0;
         misalign_err <= 1'b0;
         if (done) begin
            retired      <= retired + CNT_W'(1);
            misalign_err <= c_err;
            if (c_we) begin
               regfile_w_en   <= 1'b1;
               regfile_w_reg  <= c_rd;
               regfile_w_data <= c_data;
               for (int i = int'(BP_DEPTH) - 1; i > 0; i--) begin
                  wb_bp_valid[i]               <= wb_bp_valid[i-1];
                  wb_bp_reg[i*REG_AW +: REG_AW] <= wb_bp_reg[(i-1)*REG_AW +: REG_AW];
                  wb_bp_val[i*32 +: 32]         <= wb_bp_val[(i-1)*32 +: 32];
               end
               wb_bp_valid[0]        <= 1'b1;
               wb_bp_reg[REG_AW-1:0] <= c_rd;
               wb_bp_val[31:0]       <= c_data;
            end
         end
         unique case (state)
            StIdle: begin
               if (in_valid && is_load && !mem_r_valid) begin
                  f3_q     <= funct3;
                  addr_q   <= addr_lo;
                  rd_q     <= rd;
                  state    <= StWaitMem;
                  in_ready <= 1'b0;
               end
            end
            StWaitMem: begin
               if (mem_r_valid) begin
                  state    <= StIdle;
                  in_ready <= 1'b1;
               end
            end
            default: begin
               state    <= StIdle;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: the driver pushes expected completions from a
// behavioural model, a negedge monitor pops them and tracks write hold and bypass history.
module tb_writeback_stage;

   localparam int BP = 2;
   localparam logic [3:0] R_T = 4'd0;
   localparam logic [3:0] L_T = 4'd2;
   localparam logic [3:0] S_T = 4'd3;
   localparam logic [3:0] B_T = 4'd4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [3:0]    insn_type = 4'd0;
   logic [2:0]    funct3 = 3'd0;
   logic [1:0]    addr_lo = 2'd0;
   logic [4:0]    rd = 5'd0;
   logic [31:0]   ex_val = 32'h0;
   logic          mem_r_valid = 1'b0;
   logic [31:0]   mem_r_data = 32'h0;
   logic          regfile_w_en;
   logic [4:0]    regfile_w_reg;
   logic [31:0]   regfile_w_data;
   logic [BP-1:0] wb_bp_valid;
   logic [BP*5-1:0]  wb_bp_reg;
   logic [BP*32-1:0] wb_bp_val;
   logic          misalign_err;
   logic [31:0]   retired;

   writeback_stage #(.REG_AW(5), .BP_DEPTH(BP), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .insn_type(insn_type), .funct3(funct3), .addr_lo(addr_lo), .rd(rd), .ex_val(ex_val),
      .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data), .regfile_w_en(regfile_w_en),
      .regfile_w_reg(regfile_w_reg), .regfile_w_data(regfile_w_data),
      .wb_bp_valid(wb_bp_valid), .wb_bp_reg(wb_bp_reg), .wb_bp_val(wb_bp_val),
      .misalign_err(misalign_err), .retired(retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  r;
      logic [31:0] d;
      logic        err;
   } exp_t;

   exp_t sbq[$];
   exp_t hist[$];
   int   total = 0;
   int   bad = 0;
   logic rst_at_edge = 1'b1;

   always @(posedge clk) rst_at_edge = rst;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [3:0] t, input logic [2:0] f3,
                                  input logic [1:0] a, input logic [4:0] r,
                                  input logic [31:0] ex, input logic [31:0] md);
      exp_t e;
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] ld;
      logic        err;
      b   = md[int'(a)*8 +: 8];
      h   = a[1] ? md[31:16] : md[15:0];
      err = 1'b0;
      ld  = 32'h0;
      case (f3)
         3'b000: ld = (b[7] ? 32'hFFFF_FF00 : 32'h0) | 32'(b);
         3'b100: ld = 32'(b);
         3'b001: begin ld = (h[15] ? 32'hFFFF_0000 : 32'h0) | 32'(h); err = a[0]; end
         3'b101: begin ld = 32'(h); err = a[0]; end
         3'b010: begin ld = md; err = (a != 2'b00); end
         default: err = 1'b1;
      endcase
      e.err = (t == L_T) && err;
      e.d   = (t == L_T) ? ld : ex;
      e.r   = r;
      e.we  = (t != S_T) && (t != B_T) && (r != 5'd0) && !e.err;
      return e;
   endfunction

   // Monitor: a change of the retired count marks a completion presented by the DUT.
   initial begin : monitor
      exp_t        e;
      logic [31:0] cnt;
      logic [31:0] last_ret;
      logic [4:0]  last_r;
      logic [31:0] last_d;
      logic        ev;
      logic [4:0]  er;
      logic [31:0] evl;
      cnt = 0; last_ret = 0; last_r = 0; last_d = 0;
      forever begin
         @(negedge clk);
         if (rst_at_edge) begin
            hist.delete();
            cnt = 0; last_ret = 0; last_r = 0; last_d = 0;
            chk("rst_w_en", 32'(regfile_w_en), 0);
            chk("rst_err", 32'(misalign_err), 0);
            chk("rst_retired", retired, 0);
            chk("rst_in_ready", 32'(in_ready), 1);
         end else if (retired !== last_ret) begin
            cnt++;
            chk("retired", retired, cnt);
            last_ret = retired;
            if (sbq.size() == 0) begin
               chk("unexpected_completion", 32'(sbq.size()), 1);
            end else begin
               e = sbq.pop_front();
               chk("w_en", 32'(regfile_w_en), 32'(e.we));
               chk("misalign_err", 32'(misalign_err), 32'(e.err));
               if (e.we) begin
                  last_r = e.r;
                  last_d = e.d;
                  hist.push_front(e);
                  if (hist.size() > BP) void'(hist.pop_back());
               end
            end
         end else begin
            chk("idle_w_en", 32'(regfile_w_en), 0);
            chk("idle_err", 32'(misalign_err), 0);
         end
         chk("w_reg", 32'(regfile_w_reg), 32'(last_r));
         chk("w_data", regfile_w_data, last_d);
         for (int i = 0; i < BP; i++) begin
            if (i < hist.size()) begin
               ev = 1'b1; er = hist[i].r; evl = hist[i].d;
            end else begin
               ev = 1'b0; er = 5'd0; evl = 32'h0;
            end
            chk($sformatf("bp%0d_valid", i), 32'(wb_bp_valid[i]), 32'(ev));
            chk($sformatf("bp%0d_reg", i), 32'(wb_bp_reg[i*5 +: 5]), 32'(er));
            chk($sformatf("bp%0d_val", i), wb_bp_val[i*32 +: 32], evl);
         end
      end
   end

   task automatic issue(input logic [3:0] t, input logic [2:0] f3, input logic [1:0] a,
                        input logic [4:0] r, input logic [31:0] ex, input logic [31:0] md,
                        input int lat);
      int n;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("ready_timeout", 32'(in_ready), 1);
      sbq.push_back(model(t, f3, a, r, ex, md));
      in_valid = 1'b1; insn_type = t; funct3 = f3; addr_lo = a; rd = r; ex_val = ex;
      if (t == L_T) begin
         mem_r_valid = (lat == 0);
         mem_r_data  = (lat == 0) ? md : $urandom;
      end else begin
         mem_r_valid = 1'($urandom);
         mem_r_data  = $urandom;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; mem_r_valid = 1'b0;
      if (t == L_T && lat > 0) begin
         // Competing instructions and junk fields must not disturb the pending load.
         for (int k = 0; k < lat; k++) begin
            chk("in_ready_wait", 32'(in_ready), 0);
            in_valid = 1'b1; insn_type = R_T; funct3 = 3'($urandom); addr_lo = 2'($urandom);
            rd = 5'($urandom_range(1, 31)); ex_val = $urandom; mem_r_data = $urandom;
            @(posedge clk); #1;
         end
         chk("in_ready_wait", 32'(in_ready), 0);
         mem_r_valid = 1'b1; mem_r_data = md;
         @(posedge clk); #1;
         mem_r_valid = 1'b0; in_valid = 1'b0;
         chk("in_ready_back", 32'(in_ready), 1);
      end
   endtask

   initial begin : driver
      logic [3:0] t;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      issue(R_T, 3'd0, 2'd0, 5'd5, 32'h1234_5678, 32'h0, 0);
      issue(L_T, 3'b000, 2'd2, 5'd3, 32'h0, 32'h0080_0000, 0);
      issue(L_T, 3'b100, 2'd2, 5'd3, 32'h0, 32'h0080_0000, 0);
      issue(L_T, 3'b101, 2'd2, 5'd7, 32'h0, 32'hBEEF_0000, 3);
      issue(L_T, 3'b010, 2'd1, 5'd4, 32'h0, 32'h1111_2222, 0);
      issue(L_T, 3'b011, 2'd1, 5'd4, 32'h0, 32'h1111_2222, 0);
      issue(R_T, 3'd0, 2'd0, 5'd1, 32'd1, 32'h0, 0);
      issue(R_T, 3'd0, 2'd0, 5'd0, 32'd9, 32'h0, 0);
      issue(R_T, 3'd0, 2'd0, 5'd2, 32'd2, 32'h0, 0);
      issue(S_T, 3'd2, 2'd0, 5'd6, 32'd7, 32'h0, 0);
      // Reset while a load is pending: the load is dropped and a late response is ignored.
      in_valid = 1'b1; insn_type = L_T; funct3 = 3'b010; addr_lo = 2'd0; rd = 5'd9;
      mem_r_valid = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mem_r_valid = 1'b1; mem_r_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      mem_r_valid = 1'b0;
      chk("post_rst_retired", retired, 0);
      for (int i = 0; i < 300; i++) begin
         repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0; mem_r_valid = 1'($urandom); mem_r_data = $urandom;
            @(posedge clk); #1;
         end
         mem_r_valid = 1'b0;
         t = ($urandom_range(0, 2) == 0) ? L_T : 4'($urandom_range(0, 8));
         issue(t, 3'($urandom), 2'($urandom), 5'($urandom_range(0, 7)), $urandom,
               $urandom, ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4));
      end
      repeat (5) @(posedge clk);
      chk("sb_empty", 32'(sbq.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
